// File: rtl/rv32_pc_unit_pkg.sv
// Shared rv32 pipeline types: BTB entry layout, prediction info carried down the pipe, NOP constant.
package rv32_types;

  localparam logic [31:0] RV32_NOP_INSTR = 32'h0000_0013;

  // Sized for the largest legal configuration; narrower builds zero the upper bits.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] target;
    logic [3:0]  cnt;
  } btb_entry_t;

  typedef struct packed {
    logic        pred_taken;
    logic [31:0] pred_target;
  } bpred_info_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    bpred_info_t bpred;
  } fetch_decode_buffer_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    bpred_info_t bpred;
  } decode_exec_buffer_t;

endpackage

// File: rtl/rv32_pc_unit_if.sv
// Execute-stage resolution bundle feeding the PC unit.
interface rv32_pc_unit_if;
  import rv32_types::*;

  // ex_valid qualifies the bundle; there is no ready, every valid cycle is consumed
  // except while ex_hold is high, when the bundle stays stable and is consumed the cycle ex_hold falls.
  logic        ex_valid;
  logic        ex_hold;
  logic        ex_is_branch;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;

  modport master (
    output ex_valid, ex_hold, ex_is_branch, ex_pc, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target
  );

  modport slave (
    input ex_valid, ex_hold, ex_is_branch, ex_pc, ex_taken, ex_target,
          ex_pred_taken, ex_pred_target
  );

endinterface

// File: rtl/rv32_pc_unit_btb.sv
// Direct-mapped branch target buffer: combinational lookup, registered update, saturating counters.
module rv32_btb
  import rv32_types::*;
#(
  parameter int BTB_ENTRIES = 16,
  parameter int CNT_BITS    = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [29:0] lk_addr,
  output logic        lk_hit,
  output logic        lk_taken,
  output logic [31:0] lk_target,
  input  logic        up_en,
  input  logic [29:0] up_addr,
  input  logic        up_taken,
  input  logic [31:0] up_target
);

  localparam int         IDX      = $clog2(BTB_ENTRIES);
  localparam logic [3:0] CNT_MAX  = 4'((1 << CNT_BITS) - 1);
  localparam logic [3:0] CNT_INIT = 4'(1 << (CNT_BITS - 1));

  btb_entry_t mem [BTB_ENTRIES];

  logic [IDX-1:0] lk_idx, up_idx;
  logic [29:0]    lk_tag, up_tag;
  logic           up_hit;

  assign lk_idx = lk_addr[IDX-1:0];
  assign lk_tag = lk_addr >> IDX;
  assign up_idx = up_addr[IDX-1:0];
  assign up_tag = up_addr >> IDX;

  assign lk_hit    = mem[lk_idx].valid && (mem[lk_idx].tag == lk_tag);
  assign lk_taken  = lk_hit && mem[lk_idx].cnt[CNT_BITS-1];
  assign lk_target = mem[lk_idx].target;
  assign up_hit    = mem[up_idx].valid && (mem[up_idx].tag == up_tag);

  // Writes land at the clock edge, so a same-cycle lookup still sees the old entry.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < BTB_ENTRIES; i++) mem[i].valid <= 1'b0;
    end else if (up_en) begin
      if (up_hit) begin
        if (up_taken) begin
          if (mem[up_idx].cnt != CNT_MAX) mem[up_idx].cnt <= mem[up_idx].cnt + 4'd1;
          mem[up_idx].target <= up_target;
        end else if (mem[up_idx].cnt != 4'd0) begin
          mem[up_idx].cnt <= mem[up_idx].cnt - 4'd1;
        end
      end else if (up_taken) begin
        mem[up_idx] <= '{valid: 1'b1, tag: up_tag, target: up_target, cnt: CNT_INIT};
      end
    end
  end

endmodule

// File: rtl/rv32_pc_unit.sv
// PC register, next-PC priority mux and mispredict detection.
// Build with RV32_BPRED_EN defined to enable the BTB; otherwise prediction is static not-taken.
module rv32_pc_unit
  import rv32_types::*;
#(
  parameter int          BTB_ENTRIES = 16,
  parameter int          CNT_BITS    = 2,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               stall,
  output logic [31:0]        pc,
  output logic               pred_taken,
  output logic [31:0]        pred_target,
  rv32_pc_unit_if.slave      ex,
  output logic               flush,
  output logic [31:0]        flush_pc
);

  logic        res;
  logic        mispredict;
  logic [31:0] pc_plus4;
  logic [31:0] correct_pc;
  logic [31:0] next_pc;
  bpred_info_t bpred;

  assign pc_plus4   = pc + 32'd4;
  assign res        = ex.ex_valid & ~ex.ex_hold & ex.ex_is_branch;
  assign correct_pc = ex.ex_taken ? ex.ex_target : ex.ex_pc + 32'd4;

`ifdef RV32_BPRED_EN
  logic        btb_hit;
  logic        btb_taken;
  logic [31:0] btb_target;

  rv32_btb #(
    .BTB_ENTRIES (BTB_ENTRIES),
    .CNT_BITS    (CNT_BITS)
  ) u_btb (
    .clk       (clk),
    .resetn    (resetn),
    .lk_addr   (pc[31:2]),
    .lk_hit    (btb_hit),
    .lk_taken  (btb_taken),
    .lk_target (btb_target),
    .up_en     (res),
    .up_addr   (ex.ex_pc[31:2]),
    .up_taken  (ex.ex_taken),
    .up_target (ex.ex_target)
  );

  assign bpred      = '{pred_taken: btb_taken, pred_target: btb_hit ? btb_target : pc_plus4};
  assign mispredict = res & ((ex.ex_taken != ex.ex_pred_taken) |
                             (ex.ex_taken & (ex.ex_target != ex.ex_pred_target)));
`else
  localparam int unused_cfg = BTB_ENTRIES + CNT_BITS;
  logic unused_pred;
  assign unused_pred = ^{ex.ex_pred_taken, ex.ex_pred_target};
  assign bpred       = '{pred_taken: 1'b0, pred_target: pc_plus4};
  assign mispredict  = res & ex.ex_taken;
`endif

  assign pred_taken  = bpred.pred_taken;
  assign pred_target = bpred.pred_target;
  assign flush       = resetn & mispredict;
  assign flush_pc    = ex.ex_pc;

  // A redirect outranks stall: the squashed instructions are refetched from correct_pc.
  always_comb begin
    next_pc = pc_plus4;
    if (!resetn)               next_pc = RESET_PC;
    else if (mispredict)       next_pc = correct_pc;
    else if (stall)            next_pc = pc;
    else if (bpred.pred_taken) next_pc = bpred.pred_target;
  end

  always_ff @(posedge clk) begin
    pc <= next_pc;
  end

endmodule

// File: tb/tb_rv32_pc_unit.sv
// Directed bench for rv32_pc_unit; expectations follow RV32_BPRED_EN (BTB) or static not-taken.
module tb_rv32_pc_unit;

`ifdef RV32_BPRED_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  logic        clk;
  logic        resetn;
  logic        stall;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        flush;
  logic [31:0] flush_pc;

  int checks = 0;
  int errors = 0;

  rv32_pc_unit_if ex_if ();

  rv32_pc_unit #(
    .BTB_ENTRIES (16),
    .CNT_BITS    (2),
    .RESET_PC    (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .stall       (stall),
    .pc          (pc),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .ex          (ex_if),
    .flush       (flush),
    .flush_pc    (flush_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    ex_if.ex_valid       = 1'b0;
    ex_if.ex_hold        = 1'b0;
    ex_if.ex_is_branch   = 1'b0;
    ex_if.ex_pc          = 32'h0;
    ex_if.ex_taken       = 1'b0;
    ex_if.ex_target      = 32'h0;
    ex_if.ex_pred_taken  = 1'b0;
    ex_if.ex_pred_target = 32'h0;
    #1;
  endtask

  task automatic resolve(input logic [31:0] p, input logic t, input logic [31:0] tgt,
                         input logic pt, input logic [31:0] ptgt);
    ex_if.ex_valid       = 1'b1;
    ex_if.ex_hold        = 1'b0;
    ex_if.ex_is_branch   = 1'b1;
    ex_if.ex_pc          = p;
    ex_if.ex_taken       = t;
    ex_if.ex_target      = tgt;
    ex_if.ex_pred_taken  = pt;
    ex_if.ex_pred_target = ptgt;
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    stall  = 1'b0;
    idle();

    // Reset, with a mispredicting bundle present that must neither flush nor update.
    resolve(32'h20, 1'b1, 32'h100, 1'b0, 32'h24);
    chk("flush_in_reset", {31'b0, flush}, 32'd0);
    tick();
    tick();
    idle();
    chk("reset_pc", pc, 32'h0);
    chk("reset_pred_taken", {31'b0, pred_taken}, 32'd0);
    chk("reset_pred_target", pred_target, 32'h4);
    chk("reset_flush", {31'b0, flush}, 32'd0);
    resetn = 1'b1;
    tick(); chk("seq_pc4", pc, 32'h4);
    tick(); chk("seq_pc8", pc, 32'h8);
    tick(); chk("seq_pc12", pc, 32'hC);

    // Cold taken branch at 0x20.
    resolve(32'h20, 1'b1, 32'h100, 1'b0, 32'h24);
    chk("cold_flush", {31'b0, flush}, 32'd1);
    chk("cold_flush_pc", flush_pc, 32'h20);
    tick(); idle();
    chk("cold_next_pc", pc, 32'h100);

    // Warm prediction at 0x20.
    resolve(32'h300, 1'b1, 32'h20, 1'b0, 32'h304);
    tick(); idle();
    chk("warm_pc", pc, 32'h20);
    chk("warm_pred_taken", {31'b0, pred_taken}, {31'b0, BP});
    chk("warm_pred_target", pred_target, BP ? 32'h100 : 32'h24);
    tick();
    chk("warm_next_pc", pc, BP ? 32'h100 : 32'h24);
    resolve(32'h20, 1'b1, 32'h100, BP, BP ? 32'h100 : 32'h24);
    chk("warm_flush", {31'b0, flush}, {31'b0, ~BP});
    tick(); idle();
    chk("warm_after_pc", pc, BP ? 32'h104 : 32'h100);

    // Hysteresis: two not-taken outcomes against a taken prediction.
    resolve(32'h20, 1'b0, 32'h24, BP, 32'h100);
    chk("hyst1_flush", {31'b0, flush}, {31'b0, BP});
    tick(); idle();
    chk("hyst1_pc", pc, BP ? 32'h24 : 32'h104);
    resolve(32'h20, 1'b0, 32'h24, BP, 32'h100);
    chk("hyst2_flush", {31'b0, flush}, {31'b0, BP});
    tick(); idle();
    chk("hyst2_pc", pc, BP ? 32'h24 : 32'h108);
    resolve(32'h300, 1'b1, 32'h20, 1'b0, 32'h304);
    tick(); idle();
    chk("hyst_refetch_pc", pc, 32'h20);
    chk("hyst_pred_taken", {31'b0, pred_taken}, 32'd0);
    chk("hyst_pred_target", pred_target, BP ? 32'h100 : 32'h24);
    tick();
    chk("hyst_next_pc", pc, 32'h24);

    // Stall holds the PC; a redirect still wins over stall.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold", pc, 32'h24);
    end
    resolve(32'h40, 1'b1, 32'h200, 1'b0, 32'h44);
    chk("stall_flush", {31'b0, flush}, 32'd1);
    tick(); idle();
    chk("stall_redirect_pc", pc, 32'h200);
    tick();
    chk("stall_hold_after", pc, 32'h200);
    stall = 1'b0;

    // ex_hold blocks the redirect until it drops.
    resolve(32'h44, 1'b1, 32'h300, 1'b0, 32'h48);
    ex_if.ex_hold = 1'b1;
    #1;
    chk("hold_flush0", {31'b0, flush}, 32'd0);
    tick();
    chk("hold_pc1", pc, 32'h204);
    chk("hold_flush1", {31'b0, flush}, 32'd0);
    tick();
    chk("hold_pc2", pc, 32'h208);
    ex_if.ex_hold = 1'b0;
    #1;
    chk("hold_release_flush", {31'b0, flush}, 32'd1);
    chk("hold_release_flush_pc", flush_pc, 32'h44);
    tick(); idle();
    chk("hold_release_pc", pc, 32'h300);

    // Wrap at the top of the address space.
    resolve(32'h80, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h84);
    tick(); idle();
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_pred_taken", {31'b0, pred_taken}, 32'd0);
    chk("wrap_pred_target", pred_target, 32'h0);
    tick();
    chk("wrap_next_pc", pc, 32'h0);

    // Aliasing: 0x20 and 0x60 share an index.
    resolve(32'h84, 1'b1, 32'h60, 1'b0, 32'h88);
    tick(); idle();
    chk("alias_pc60", pc, 32'h60);
    chk("alias_miss60", {31'b0, pred_taken}, 32'd0);
    chk("alias_miss60_target", pred_target, 32'h64);
    resolve(32'h60, 1'b1, 32'h400, 1'b0, 32'h64);
    chk("alias_same_cycle_old", {31'b0, pred_taken}, 32'd0);
    chk("alias_alloc_flush", {31'b0, flush}, 32'd1);
    tick(); idle();
    chk("alias_pc400", pc, 32'h400);
    resolve(32'h88, 1'b1, 32'h20, 1'b0, 32'h8C);
    tick(); idle();
    chk("alias_evicted_taken", {31'b0, pred_taken}, 32'd0);
    chk("alias_evicted_target", pred_target, 32'h24);
    resolve(32'h8C, 1'b1, 32'h60, 1'b0, 32'h90);
    tick(); idle();
    chk("alias_hit60_taken", {31'b0, pred_taken}, {31'b0, BP});
    chk("alias_hit60_target", pred_target, BP ? 32'h400 : 32'h64);

    // Reset mid-operation empties the BTB and drops the pending update.
    resetn = 1'b0;
    resolve(32'h60, 1'b1, 32'h500, 1'b0, 32'h64);
    chk("midreset_flush", {31'b0, flush}, 32'd0);
    tick(); idle();
    chk("midreset_pc", pc, 32'h0);
    resetn = 1'b1;
    resolve(32'h90, 1'b1, 32'h60, 1'b0, 32'h94);
    tick(); idle();
    chk("midreset_refetch_pc", pc, 32'h60);
    chk("midreset_btb_empty", {31'b0, pred_taken}, 32'd0);
    chk("midreset_pred_target", pred_target, 32'h64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
